// File: rtl/mesh_db_round_if.sv
// Request/response bus of the round-based mesh database port.
//   in_valid / in_ready / in_last : beat handshake, in_last marks the final beat of a round
//   in_pkt   : LANES request packets, lane i = {vld, wr, addr, data}, lane 0 in LSBs
//   out_valid / out_data : response beat, lane i = {hit, data}, lane 0 in LSBs
// master drives requests (traffic source), slave is the database port.
interface mesh_db_round_if #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                                        in_valid;
    logic                                        in_ready;
    logic                                        in_last;
    logic [LANES*(ADDR_WIDTH+DATA_WIDTH+2)-1:0]  in_pkt;
    logic                                        out_valid;
    logic [LANES*(DATA_WIDTH+1)-1:0]             out_data;

    modport master (
        output in_valid, in_last, in_pkt,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_last, in_pkt,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mesh_db_round.sv
// Round-based multi-lane read/write database port for the Nanci mesh.
// Reads are served from the committed (pre-round) image; writes are buffered per
// address and committed atomically when the round closes, last writer wins.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   start        : opens a round, honoured in IDLE only
//   bus          : request/response bus (slave side)
//   done         : one-cycle pulse after the commit
//   busy         : FSM not in IDLE
//   write_count  : distinct addresses written in the last committed round
//   mem_flat     : committed memory image, entry 0 in LSBs
module mesh_db_round #(
    parameter int unsigned N          = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    mesh_db_round_if.slave             bus,
    output logic                       done,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       write_count,
    output logic [N*DATA_WIDTH-1:0]    mem_flat
);
    localparam int unsigned PW = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int unsigned RW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StAccept, StCommit} state_e;

    state_e state_q, state_d;

    logic                                 ready;
    logic                                 commit_en;
    logic                                 accept;

    logic [N-1:0][DATA_WIDTH-1:0]         mem_q, mem_d;
    logic [N-1:0][DATA_WIDTH-1:0]         pend_data_q, pend_data_d;
    logic [N-1:0]                         pend_q, pend_d;
    logic [CNT_WIDTH-1:0]                 write_count_q, pend_cnt;
    logic                                 done_q;
    logic                                 out_valid_q;
    logic [LANES*RW-1:0]                  out_data_q, resp_d;

    logic                                 lane_vld  [LANES];
    logic                                 lane_wr   [LANES];
    logic                                 lane_ok   [LANES];
    logic [ADDR_WIDTH-1:0]                lane_addr [LANES];
    logic [DATA_WIDTH-1:0]                lane_data [LANES];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StAccept;
            StAccept: if (bus.in_valid && bus.in_last) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready     = 1'b0;
        commit_en = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle:   busy      = 1'b0;
            StAccept: ready     = 1'b1;
            StCommit: commit_en = 1'b1;
            default:  busy      = 1'b0;
        endcase
    end

    assign bus.in_ready = ready;
    assign accept       = bus.in_valid & ready;

    // Lane field extraction: {vld, wr, addr, data}.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_data[l] = bus.in_pkt[l*PW +: DATA_WIDTH];
            lane_addr[l] = bus.in_pkt[l*PW + DATA_WIDTH +: ADDR_WIDTH];
            lane_wr[l]   = bus.in_pkt[l*PW + DATA_WIDTH + ADDR_WIDTH];
            lane_vld[l]  = bus.in_pkt[l*PW + DATA_WIDTH + ADDR_WIDTH + 1];
            lane_ok[l]   = 32'(lane_addr[l]) < N;
        end
    end

    // Pending buffer. Lanes are walked in ascending order so the highest lane
    // writing an address overrides lower ones within the same beat.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (commit_en) begin
            pend_d = '0;
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_vld[l] && lane_wr[l] && lane_ok[l]) begin
                    pend_d[lane_addr[l]]      = 1'b1;
                    pend_data_d[lane_addr[l]] = lane_data[l];
                end
            end
        end
    end

    // Read responses always see the committed image, never pending data.
    always_comb begin
        resp_d = '0;
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_vld[l] && !lane_wr[l] && lane_ok[l]) begin
                    resp_d[l*RW +: RW] = {1'b1, mem_q[lane_addr[l]]};
                end
            end
        end
    end

    // Commit image and the count of distinct addresses written this round.
    always_comb begin
        mem_d    = mem_q;
        pend_cnt = '0;
        for (int a = 0; a < N; a++) begin
            pend_cnt = pend_cnt + CNT_WIDTH'(pend_q[a]);
            if (commit_en && pend_q[a]) begin
                mem_d[a] = pend_data_q[a];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q         <= '0;
            pend_q        <= '0;
            pend_data_q   <= '0;
            write_count_q <= '0;
            done_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            done_q      <= commit_en;
            out_valid_q <= accept;
            out_data_q  <= resp_d;
            if (commit_en) begin
                write_count_q <= pend_cnt;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign done          = done_q;
    assign write_count   = write_count_q;
    assign mem_flat      = mem_q;

endmodule

// File: doc/mesh_db_round.md
Name: mesh_db_round

Overview:
- Multi-lane, round-based read/write database port for the Nanci mesh.
- Accepts LANES request packets per beat over a valid/ready handshake, serves reads from the pre-round memory image and buffers writes.
- At round end it commits all buffered writes atomically, last writer wins.
- Generalises the fixed-size, write-only mesh database to configurable depth, width and lane count, with reads, explicit rounds and conflict resolution.

Parameters:
- N, 16, number of memory entries (N <= 2^ADDR_WIDTH).
- ADDR_WIDTH, 4, address field width.
- DATA_WIDTH, 8, data field width.
- LANES, 4, request packets per beat.
- CNT_WIDTH, 5, width of write_count (must hold N).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; opens a round; honoured in IDLE only.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts a beat; equals 1 exactly in ACCEPT.
- in_last  in  1  accepted beat is the final beat of the round.
- in_pkt  in  LANES*(ADDR_WIDTH+DATA_WIDTH+2)  lane i packet, lane 0 in LSBs: {vld, wr, addr, data}.
- out_valid  out  1  response beat present.
- out_data  out  LANES*(DATA_WIDTH+1)  lane i response: {hit, data}.
- done  out  1  one-cycle pulse after commit.
- busy  out  1  state != IDLE.
- write_count  out  CNT_WIDTH  distinct addresses written in the last committed round.
- mem_flat  out  N*DATA_WIDTH  memory image, entry 0 in LSBs.

Behaviour:
- Reset (rst=0, asynchronous):
  - All memory entries, pending buffer, FSM state and outputs go to 0.
  - State is IDLE; in_ready=0.
  - An in-flight round is discarded; no done pulse.
- FSM states IDLE, ACCEPT, COMMIT:
  - IDLE: start=1 moves to ACCEPT next cycle. Beats are not accepted.
  - ACCEPT: a beat is accepted when in_valid & in_ready. If in_last=1 on an accepted beat, move to COMMIT; otherwise remain. Gaps in in_valid are allowed. start is ignored.
  - COMMIT: lasts exactly 1 cycle, then IDLE. in_ready=0. start is ignored.
- Pending buffer: per-address data plus pending bit, N entries.
- Write lane (vld=1, wr=1, addr<N):
  - Sets the pending bit and pending data for that address.
  - Same beat: the higher lane index wins.
  - Across beats: the later beat wins.
  - addr>=N: the write is silently dropped.
- Read lane (vld=1, wr=0):
  - Response in the cycle after acceptance.
  - addr<N: hit=1, data = committed memory value (pre-round); pending writes are not visible.
  - addr>=N: hit=0, data=0.
- Lane with vld=0, or a write lane: response {0, 0}.
- out_valid:
  - 1 for exactly one cycle after each accepted beat, 0 otherwise.
  - No backpressure; out_data is held only while out_valid=1 and is 0 otherwise.
- COMMIT cycle, on its closing edge:
  - mem[a] <= pending data for every a with its pending bit set.
  - All pending bits cleared.
  - write_count <= popcount(pending bits).
- Timing: beat with in_last accepted at edge t → COMMIT during cycle t+1 → memory updated and done=1 during cycle t+2 (state IDLE). start is accepted in that same cycle.
- write_count holds its value until the next commit. A round with no writes commits write_count=0 and leaves memory unchanged.
- mem_flat reflects committed memory only, never pending data.

Test Plan:
1. Round with one beat, in_last=1; lanes 0..3 write 0xAA to addrs 0..3 → out_valid=1 with all lanes {0,0}; done 2 cycles after acceptance; write_count=4; mem[0..3]=0xAA; mem[4..15]=0.
2. Same-beat conflict: lane 0 writes addr 5=0x11, lane 2 writes addr 5=0x22 → mem[5]=0x22, write_count=1.
3. Cross-beat: beat 1 lane 3 writes addr 7=0x33; beat 2 lane 0 writes addr 7=0x44 and lane 1 reads addr 7.
   - Beat 2 response: lane 1 = {1,0x00}.
   - After commit: mem[7]=0x44, write_count=1.
   - Next round, read of addr 7 → {1,0x44}.
4. in_valid low for 3 cycles inside ACCEPT, plus start pulses during ACCEPT and COMMIT → no extra beats or responses; a single done pulse; state sequence IDLE→ACCEPT→COMMIT→IDLE.
5. Assert rst after 2 accepted write beats, before in_last → mem_flat=0, write_count=0, in_ready=0, no done. A fresh round after release writes addr 1=0x5A → mem[1]=0x5A, write_count=1.
6. Instance with N=12: write addr 14=0xFF and read addr 14 in one beat → read response {0,0x00}; write_count=0; memory unchanged.
